// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: USB full-speed transmit path.
// Takes packet bytes over a valid/ready handshake, prepends SYNC, serializes
// LSB-first with bit stuffing and NRZI, and closes each packet with EOP
// (SE0, SE0, J). Every output is registered.
//
// Handshake: a byte is accepted on a rising clk edge when tx_data_valid and
// tx_data_ready are both high; while valid is high without ready the source
// holds tx_data/tx_last stable. tx_data_ready never depends combinationally
// on tx_data_valid.
//
// Optional feature: define USB_TX_ABORT_EN to add the tx_abort input, which
// ends a packet with seven unstuffed 1 bits followed by EOP.
//
// dbg_state exposes the FSM state for checkers.
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  input  logic       tx_last,
`ifdef USB_TX_ABORT_EN
  input  logic       tx_abort,
`endif
  output logic       tx_data_ready,
  output logic       d_plus_out,
  output logic       d_minus_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [2:0] dbg_state
);

  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int ONES_W = $clog2(STUFF_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SYNC    = 3'd1,
    S_DATA    = 3'd2,
    S_EOP_SE0 = 3'd3,
    S_EOP_J   = 3'd4,
    S_ABORT   = 3'd5
  } state_t;

  state_t              r_state,     w_state_nxt;
  logic [CNT_W-1:0]    r_bit_cnt,   w_bit_cnt_nxt;
  logic [6:0]          r_shift,     w_shift_nxt;
  logic [2:0]          r_bits_left, w_bits_left_nxt;
  logic                r_cur_last,  w_cur_last_nxt;
  logic [ONES_W-1:0]   r_ones,      w_ones_nxt;
  logic                r_eop_cnt,   w_eop_cnt_nxt;
  logic [7:0]          r_hold,      w_hold_nxt;
  logic                r_hold_full, w_hold_full_nxt;
  logic                r_hold_last, w_hold_last_nxt;
  logic                r_last_acc,  w_last_acc_nxt;
  logic                r_dp,        w_dp_nxt;
  logic                r_dm,        w_dm_nxt;
  logic                r_busy,      w_busy_nxt;
  logic                r_done,      w_done_nxt;
  logic                r_error,     w_error_nxt;
  logic                r_ready,     w_ready_nxt;
`ifdef USB_TX_ABORT_EN
  logic [2:0]          r_abort_cnt, w_abort_cnt_nxt;
`endif

  logic w_boundary;
  logic w_accept;
  logic w_emit;
  logic w_emit_bit;

  assign w_boundary = (r_bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_accept   = tx_data_valid & r_ready;

  // State and datapath registers; reset parks the lines at idle J.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_bits_left <= '0;
      r_cur_last  <= 1'b0;
      r_ones      <= '0;
      r_eop_cnt   <= 1'b0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_hold_last <= 1'b0;
      r_last_acc  <= 1'b0;
      r_dp        <= 1'b1;
      r_dm        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_ready     <= 1'b1;
`ifdef USB_TX_ABORT_EN
      r_abort_cnt <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_bits_left <= w_bits_left_nxt;
      r_cur_last  <= w_cur_last_nxt;
      r_ones      <= w_ones_nxt;
      r_eop_cnt   <= w_eop_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_hold_last <= w_hold_last_nxt;
      r_last_acc  <= w_last_acc_nxt;
      r_dp        <= w_dp_nxt;
      r_dm        <= w_dm_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
      r_ready     <= w_ready_nxt;
`ifdef USB_TX_ABORT_EN
      r_abort_cnt <= w_abort_cnt_nxt;
`endif
    end
  end

  // Next-state, bit selection, stuffing, NRZI and handshake logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = '0;
    w_shift_nxt     = r_shift;
    w_bits_left_nxt = r_bits_left;
    w_cur_last_nxt  = r_cur_last;
    w_ones_nxt      = r_ones;
    w_eop_cnt_nxt   = r_eop_cnt;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_hold_last_nxt = r_hold_last;
    w_last_acc_nxt  = r_last_acc;
    w_dp_nxt        = r_dp;
    w_dm_nxt        = r_dm;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_error_nxt     = 1'b0;
    w_emit          = 1'b0;
    w_emit_bit      = 1'b0;
`ifdef USB_TX_ABORT_EN
    w_abort_cnt_nxt = r_abort_cnt;
`endif

    // Bit-time counter runs only while a packet is on the wire.
    if (r_state != S_IDLE) begin
      w_bit_cnt_nxt = w_boundary ? '0 : r_bit_cnt + CNT_W'(1);
    end

    // Byte accepted into the holding register.
    if (w_accept) begin
      w_hold_nxt      = tx_data;
      w_hold_full_nxt = 1'b1;
      w_hold_last_nxt = tx_last;
      w_last_acc_nxt  = r_last_acc | tx_last;
    end

    case (r_state)
      S_IDLE: begin
        if (tx_start) begin
          // SYNC is 0x80 sent LSB-first; bit 0 goes out right away.
          w_state_nxt     = S_SYNC;
          w_busy_nxt      = 1'b1;
          w_shift_nxt     = 7'h40;
          w_bits_left_nxt = 3'd7;
          w_cur_last_nxt  = 1'b0;
          w_ones_nxt      = '0;
          w_emit          = 1'b1;
          w_emit_bit      = 1'b0;
        end
      end
      S_SYNC, S_DATA: begin
        if (w_boundary) begin
          if (r_ones == ONES_W'(STUFF_LIMIT)) begin
            // Stuffed 0; the shift register stalls for this bit time.
            w_emit     = 1'b1;
            w_emit_bit = 1'b0;
          end else if (r_bits_left != 3'd0) begin
            w_emit          = 1'b1;
            w_emit_bit      = r_shift[0];
            w_shift_nxt     = {1'b0, r_shift[6:1]};
            w_bits_left_nxt = r_bits_left - 3'd1;
          end else if (r_cur_last) begin
            w_state_nxt   = S_EOP_SE0;
            w_eop_cnt_nxt = 1'b0;
            w_dp_nxt      = 1'b0;
            w_dm_nxt      = 1'b0;
          end else if (r_hold_full) begin
            w_state_nxt     = S_DATA;
            w_emit          = 1'b1;
            w_emit_bit      = r_hold[0];
            w_shift_nxt     = r_hold[7:1];
            w_bits_left_nxt = 3'd7;
            w_cur_last_nxt  = r_hold_last;
            w_hold_full_nxt = 1'b0;
          end else begin
            // Underflow: nothing to send and no last byte seen.
            w_state_nxt   = S_EOP_SE0;
            w_eop_cnt_nxt = 1'b0;
            w_dp_nxt      = 1'b0;
            w_dm_nxt      = 1'b0;
            w_error_nxt   = 1'b1;
          end
        end
      end
      S_EOP_SE0: begin
        if (w_boundary) begin
          if (!r_eop_cnt) begin
            w_eop_cnt_nxt = 1'b1;
          end else begin
            w_state_nxt = S_EOP_J;
            w_dp_nxt    = 1'b1;
            w_dm_nxt    = 1'b0;
          end
        end
      end
      S_EOP_J: begin
        if (w_boundary) begin
          w_state_nxt    = S_IDLE;
          w_busy_nxt     = 1'b0;
          w_done_nxt     = 1'b1;
          w_last_acc_nxt = 1'b0;
        end
      end
`ifdef USB_TX_ABORT_EN
      S_ABORT: begin
        // Held line (1 bits) with stuffing suppressed, then EOP.
        if (w_boundary) begin
          if (r_abort_cnt != 3'd7) begin
            w_abort_cnt_nxt = r_abort_cnt + 3'd1;
          end else begin
            w_state_nxt   = S_EOP_SE0;
            w_eop_cnt_nxt = 1'b0;
            w_dp_nxt      = 1'b0;
            w_dm_nxt      = 1'b0;
          end
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // NRZI: a 0 toggles the line, a 1 holds it; stuffing counter tracks 1s.
    if (w_emit) begin
      if (!w_emit_bit) begin
        w_dp_nxt   = ~r_dp;
        w_dm_nxt   = ~r_dm;
        w_ones_nxt = '0;
      end else begin
        w_ones_nxt = r_ones + ONES_W'(1);
      end
    end

`ifdef USB_TX_ABORT_EN
    // Abort discards queued data; the current bit finishes unless this is
    // already a boundary, in which case the first held bit starts now.
    if (tx_abort && (r_state == S_SYNC || r_state == S_DATA)) begin
      w_state_nxt     = S_ABORT;
      w_hold_full_nxt = 1'b0;
      w_shift_nxt     = '0;
      w_bits_left_nxt = 3'd0;
      w_cur_last_nxt  = 1'b0;
      w_ones_nxt      = '0;
      w_error_nxt     = 1'b1;
      w_dp_nxt        = r_dp;
      w_dm_nxt        = r_dm;
      w_abort_cnt_nxt = w_boundary ? 3'd1 : 3'd0;
    end
`endif

    w_ready_nxt = ~w_hold_full_nxt & ~w_last_acc_nxt &
                  (w_state_nxt != S_EOP_SE0) & (w_state_nxt != S_EOP_J) &
                  (w_state_nxt != S_ABORT);
  end

  assign tx_data_ready = r_ready;
  assign d_plus_out    = r_dp;
  assign d_minus_out   = r_dm;
  assign tx_busy       = r_busy;
  assign tx_done       = r_done;
  assign tx_error      = r_error;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: directed and randomized packets compared bit time by
// bit time against a line model built from SYNC + data bits, stuffing,
// NRZI and EOP.
module tb_usb_tx_encoder;

  localparam int C     = 8;
  localparam int STUFF = 6;
  localparam int W     = 2;

  logic       clk;
  logic       n_rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_last;
  logic       tx_data_ready;
  logic       d_plus_out;
  logic       d_minus_out;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic [2:0] dbg_state;
`ifdef USB_TX_ABORT_EN
  logic       tx_abort;
`endif

  logic [W-1:0] exp_q[$];
  logic [7:0]   pkt_q[$];
  int n_checks;
  int n_errors;
  int done_n;

  usb_tx_encoder #(.CLKS_PER_BIT(C), .STUFF_LIMIT(STUFF)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_data_valid(tx_data_valid),
    .tx_last      (tx_last),
`ifdef USB_TX_ABORT_EN
    .tx_abort     (tx_abort),
`endif
    .tx_data_ready(tx_data_ready),
    .d_plus_out   (d_plus_out),
    .d_minus_out  (d_minus_out),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx_error     (tx_error),
    .dbg_state    (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line model: J=10, K=01, SE0=00, one entry per bit time.
  function automatic void build_model(input int n_bytes);
    logic [W-1:0] line;
    int ones;
    bit bits[$];
    exp_q.delete();
    for (int i = 0; i < 7; i++) bits.push_back(1'b0);
    bits.push_back(1'b1);
    for (int b = 0; b < n_bytes; b++)
      for (int i = 0; i < 8; i++) bits.push_back(pkt_q[b][i]);
    line = 2'b10;
    ones = 0;
    foreach (bits[i]) begin
      if (!bits[i]) begin
        line = ~line;
        ones = 0;
      end else begin
        ones++;
      end
      exp_q.push_back(line);
      if (ones == STUFF) begin
        line = ~line;
        ones = 0;
        exp_q.push_back(line);
      end
    end
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endfunction

  // Drives one packet (feeding bytes whenever ready) and checks every bit
  // time, the done/error pulses and the idle state afterwards.
  // Called at a negedge; n counts posedges after the tx_start edge (n=0).
  task automatic run_packet(input int n_send, input bit give_last, input int start_at,
                            input int extra_at, input int abort_at,
                            input int exp_err_cnt, input int exp_err_n,
                            output int got_done_n);
    int idx, n, k, limit, err_n, done_cnt, err_cnt;
    bit will_accept;
    idx = 0; err_n = -1; done_cnt = 0; err_cnt = 0; got_done_n = -1;
    limit = start_at + exp_q.size() * C + 12;
    for (int t = 0; t < limit; t++) begin
      tx_start = (t == start_at) || (extra_at > 0 && t == start_at + extra_at);
`ifdef USB_TX_ABORT_EN
      tx_abort = (abort_at >= 0) && (t == start_at + abort_at);
`endif
      if (idx < n_send) begin
        tx_data_valid = 1'b1;
        tx_data       = pkt_q[idx];
        tx_last       = give_last && (idx == n_send - 1);
      end else begin
        tx_data_valid = 1'b0;
        tx_data       = 8'h00;
        tx_last       = 1'b0;
      end
      will_accept = tx_data_valid && tx_data_ready;
      @(negedge clk);
      if (will_accept) idx++;
      n = t - start_at;
      if (n >= 0) begin
        if (n == 0) check("busy_at_start", {31'd0, tx_busy}, 32'd1);
        if (n % C == C / 2) begin
          k = n / C;
          if (k < exp_q.size())
            check($sformatf("line_bit_%0d", k), {30'd0, d_plus_out, d_minus_out}, {30'd0, exp_q[k]});
        end
        if (tx_done) begin
          done_cnt++;
          if (got_done_n < 0) got_done_n = n;
        end
        if (tx_error) begin
          err_cnt++;
          if (err_n < 0) err_n = n;
        end
      end
    end
    tx_start = 1'b0;
    tx_data_valid = 1'b0;
    tx_last = 1'b0;
`ifdef USB_TX_ABORT_EN
    tx_abort = 1'b0;
`endif
    check("done_count", done_cnt, 1);
    check("done_time", got_done_n, exp_q.size() * C);
    check("error_count", err_cnt, exp_err_cnt);
    if (exp_err_cnt > 0) check("error_time", err_n, exp_err_n);
    check("busy_after", {31'd0, tx_busy}, 32'd0);
    check("ready_after", {31'd0, tx_data_ready}, 32'd1);
    check("line_after", {30'd0, d_plus_out, d_minus_out}, 32'd2);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_rst = 1'b0;
    tx_start = 1'b0;
    tx_data = 8'h00;
    tx_data_valid = 1'b0;
    tx_last = 1'b0;
`ifdef USB_TX_ABORT_EN
    tx_abort = 1'b0;
`endif

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_dp", {31'd0, d_plus_out}, 32'd1);
    check("rst_dm", {31'd0, d_minus_out}, 32'd0);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    check("rst_error", {31'd0, tx_error}, 32'd0);
    check("rst_ready", {31'd0, tx_data_ready}, 32'd1);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Preloaded 0xC3 as last byte: directed line sequence
    pkt_q = '{8'hC3};
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01,
              2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01,
              2'b00, 2'b00, 2'b10};
    run_packet(1, 1'b1, 3, 0, -1, 0, 0, done_n);
    check("c3_done_152", done_n, 152);

    // 0xFF then 0x00: one stuffed bit
    pkt_q = '{8'hFF, 8'h00};
    build_model(2);
    run_packet(2, 1'b1, 2, 0, -1, 0, 0, done_n);
    check("ff00_done_224", done_n, 224);

    // tx_start while busy is ignored
    pkt_q = '{8'hC3};
    build_model(1);
    run_packet(1, 1'b1, 2, 40, -1, 0, 0, done_n);
    check("restart_done_152", done_n, 152);

    // Underflow: second byte withheld
    pkt_q = '{8'h3C, 8'h99};
    build_model(1);
    run_packet(1, 1'b0, 1, 0, -1, 1, (exp_q.size() - 3) * C, done_n);

    // Reset mid-DATA
    tx_data = 8'h5A;
    tx_data_valid = 1'b1;
    tx_last = 1'b0;
    @(negedge clk);
    tx_data_valid = 1'b0;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_busy", {31'd0, tx_busy}, 32'd1);
    #2 n_rst = 1'b0;
    #1;
    check("mid_rst_line", {30'd0, d_plus_out, d_minus_out}, 32'd2);
    check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
    check("mid_rst_ready", {31'd0, tx_data_ready}, 32'd1);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    pkt_q = '{8'hA7, 8'h7E};
    build_model(2);
    run_packet(2, 1'b1, 1, 0, -1, 0, 0, done_n);

    // Randomized packets
    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(1, 4);
      pkt_q.delete();
      for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
      build_model(len);
      run_packet(len, 1'b1, $urandom_range(0, 3), 0, -1, 0, 0, done_n);
    end

`ifdef USB_TX_ABORT_EN
    // Abort mid-bit: current bit completes, 7 held bits, then EOP
    begin
      logic [W-1:0] held;
      pkt_q = '{8'h00, 8'h00};
      build_model(2);
      while (exp_q.size() > 11) void'(exp_q.pop_back());
      held = exp_q[10];
      for (int i = 0; i < 7; i++) exp_q.push_back(held);
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b10);
      run_packet(2, 1'b1, 1, 0, 10 * C + 3, 1, 10 * C + 3, done_n);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
